// File: rtl/cpu_rf_sb_if.sv
// cpu_rf_sb_if -- bundle of operand-read, writeback, issue and error signals
// between the pipeline and the cpu_rf_sb register file.
//
// Signals (ADDR_W = $clog2(NUM_REGS)):
//   rd_sel       NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      NUM_RD*DATA_W  read data (combinational)
//   rd_busy      NUM_RD         operand still owned by an in-flight producer
//   wr_en        NUM_WR         write enables, higher index has priority
//   wr_sel       NUM_WR*ADDR_W  write addresses
//   wr_data      NUM_WR*DATA_W  write data
//   iss_en       1              mark iss_sel busy
//   iss_sel      ADDR_W         destination being issued
//   err_clr      1              clear both sticky error flags
//   err_zero     1              sticky: nonzero write to R0 seen
//   err_conflict 1              sticky: two writes hit one nonzero register
//
// Modports: master = pipeline side, slave = register file.
interface cpu_rf_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD*ADDR_W-1:0] rd_sel;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_sel;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_sel;
    logic                     err_clr;
    logic                     err_zero;
    logic                     err_conflict;

    modport master (
        output rd_sel,
        input  rd_data,
        input  rd_busy,
        output wr_en,
        output wr_sel,
        output wr_data,
        output iss_en,
        output iss_sel,
        output err_clr,
        input  err_zero,
        input  err_conflict
    );

    modport slave (
        input  rd_sel,
        output rd_data,
        output rd_busy,
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  iss_en,
        input  iss_sel,
        input  err_clr,
        output err_zero,
        output err_conflict
    );
endinterface

// File: rtl/cpu_rf_sb.sv
// cpu_rf_sb -- multi-ported register file with hardwired-zero R0,
// same-cycle write-to-read bypass, per-register busy scoreboard and
// sticky error flags.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset; also forces read outputs to 0
//   bus    cpu_rf_sb_if.slave: read ports, write ports, issue, error flags
//
// Parameters must match those of the connected interface instance.
module cpu_rf_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_rf_sb_if.slave     bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                err_zero_q;
    logic                err_conflict_q;

    // Per-register write resolution: hit[r] if any enabled port targets r,
    // wr_val[r] is the data of the highest-index such port (later loop
    // iterations overwrite earlier ones).
    logic [NUM_REGS-1:0] hit;
    logic [DATA_W-1:0]   wr_val [NUM_REGS];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            hit[r]    = 1'b0;
            wr_val[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && bus.wr_sel[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    hit[r]    = 1'b1;
                    wr_val[r] = bus.wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Error set conditions for this cycle's writes.
    logic zero_set;
    logic conflict_set;

    always_comb begin
        zero_set     = 1'b0;
        conflict_set = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w] && bus.wr_sel[w*ADDR_W +: ADDR_W] == '0 &&
                bus.wr_data[w*DATA_W +: DATA_W] != '0)
                zero_set = 1'b1;
            for (int v = w + 1; v < NUM_WR; v++) begin
                if (bus.wr_en[w] && bus.wr_en[v] &&
                    bus.wr_sel[w*ADDR_W +: ADDR_W] == bus.wr_sel[v*ADDR_W +: ADDR_W] &&
                    bus.wr_sel[w*ADDR_W +: ADDR_W] != '0)
                    conflict_set = 1'b1;
            end
        end
    end

    // Read ports: pure mux plus bypass, gated to zero while in reset.
    // busy[0] is never set, so R0 never reports busy.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        assign idx = bus.rd_sel[i*ADDR_W +: ADDR_W];
        assign bus.rd_data[i*DATA_W +: DATA_W] =
            (!rst_n || idx == '0) ? '0 :
            hit[idx]              ? wr_val[idx] :
                                    regs[idx];
        assign bus.rd_busy[i] = rst_n & busy[idx] & ~hit[idx];
    end

    // Storage, scoreboard and sticky flags. R0 is never written. Issue
    // outranks a same-cycle write because the new producer supersedes the
    // one being retired. Flag set outranks err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy           <= '0;
            err_zero_q     <= 1'b0;
            err_conflict_q <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (hit[r])
                    regs[r] <= wr_val[r];
                if (bus.iss_en && bus.iss_sel == ADDR_W'(r))
                    busy[r] <= 1'b1;
                else if (hit[r])
                    busy[r] <= 1'b0;
            end
            err_zero_q     <= zero_set     | (err_zero_q     & ~bus.err_clr);
            err_conflict_q <= conflict_set | (err_conflict_q & ~bus.err_clr);
        end
    end

    assign bus.err_zero     = err_zero_q;
    assign bus.err_conflict = err_conflict_q;
endmodule

// File: tb/tb_cpu_rf_sb.sv
// tb_cpu_rf_sb -- directed self-checking bench for cpu_rf_sb with default
// parameters (32-bit, 16 regs, 2 read ports, 2 write ports).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 units later, well away from either clock edge.
module tb_cpu_rf_sb;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int ADDR_W   = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    cpu_rf_sb_if #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) bus ();

    cpu_rf_sb #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] rd0, rd1;
    assign rd0 = bus.rd_data[0 +: DATA_W];
    assign rd1 = bus.rd_data[DATA_W +: DATA_W];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        bus.wr_en   = '0;
        bus.wr_sel  = '0;
        bus.wr_data = '0;
        bus.iss_en  = 1'b0;
        bus.iss_sel = '0;
        bus.err_clr = 1'b0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1);
        bus.rd_sel = {s1, s0};
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] data);
        bus.wr_en[p] = 1'b1;
        bus.wr_sel[p*ADDR_W +: ADDR_W] = sel;
        bus.wr_data[p*DATA_W +: DATA_W] = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_rd(4'd5, 4'd0);
        set_wr(0, 4'd5, 32'h1234_5678);
        #2;
        n_cmp++;
        if (rd0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data0: got %h expected %h", rd0, 32'h0);
        end
        n_cmp++;
        if (bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rd_busy: got %b expected %b", bus.rd_busy, 2'b00);
        end
        n_cmp++;
        if ({bus.err_zero, bus.err_conflict} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected %b", {bus.err_zero, bus.err_conflict}, 2'b00);
        end
        tick();
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write_bypass();
        tick();
        idle();
        set_rd(4'd5, 4'd0);
        set_wr(0, 4'd5, 32'hDEAD_BEEF);
        settle();
        n_cmp++;
        if (rd0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_r5: got %h expected %h", rd0, 32'hDEAD_BEEF);
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (rd0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL stored_r5: got %h expected %h", rd0, 32'hDEAD_BEEF);
        end
        // Two different registers on both ports: no conflict, each bypassed.
        tick();
        idle();
        set_rd(4'd10, 4'd11);
        set_wr(0, 4'd10, 32'h0000_00AA);
        set_wr(1, 4'd11, 32'h0000_00BB);
        settle();
        n_cmp++;
        if ({rd1, rd0} !== {32'h0000_00BB, 32'h0000_00AA}) begin
            n_fail++;
            $display("FAIL bypass_two_ports: got %h expected %h", {rd1, rd0}, {32'h0000_00BB, 32'h0000_00AA});
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.err_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL no_false_conflict: got %b expected %b", bus.err_conflict, 1'b0);
        end
        n_cmp++;
        if ({rd1, rd0} !== {32'h0000_00BB, 32'h0000_00AA}) begin
            n_fail++;
            $display("FAIL stored_two_ports: got %h expected %h", {rd1, rd0}, {32'h0000_00BB, 32'h0000_00AA});
        end
    endtask

    task automatic test_conflict();
        tick();
        idle();
        set_rd(4'd3, 4'd0);
        set_wr(0, 4'd3, 32'h0000_1111);
        set_wr(1, 4'd3, 32'h0000_2222);
        settle();
        n_cmp++;
        if (rd0 !== 32'h0000_2222) begin
            n_fail++;
            $display("FAIL conflict_bypass_prio: got %h expected %h", rd0, 32'h0000_2222);
        end
        n_cmp++;
        if (bus.err_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_not_yet: got %b expected %b", bus.err_conflict, 1'b0);
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (rd0 !== 32'h0000_2222) begin
            n_fail++;
            $display("FAIL conflict_stored_prio: got %h expected %h", rd0, 32'h0000_2222);
        end
        n_cmp++;
        if (bus.err_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set: got %b expected %b", bus.err_conflict, 1'b1);
        end
        tick();
        settle();
        n_cmp++;
        if (bus.err_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b expected %b", bus.err_conflict, 1'b1);
        end
        n_cmp++;
        if (bus.err_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_no_err_zero: got %b expected %b", bus.err_zero, 1'b0);
        end
        bus.err_clr = 1'b1;
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.err_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_clear: got %b expected %b", bus.err_conflict, 1'b0);
        end
    endtask

    task automatic test_zero_reg();
        tick();
        idle();
        set_rd(4'd0, 4'd0);
        set_wr(0, 4'd0, 32'h0000_0001);
        settle();
        n_cmp++;
        if (rd0 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_bypass_zero: got %h expected %h", rd0, 32'h0);
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (rd0 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_stored_zero: got %h expected %h", rd0, 32'h0);
        end
        n_cmp++;
        if (bus.err_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL err_zero_set: got %b expected %b", bus.err_zero, 1'b1);
        end
        bus.err_clr = 1'b1;
        tick();
        idle();
        set_wr(1, 4'd0, 32'h0);
        settle();
        n_cmp++;
        if (bus.err_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL err_zero_clear: got %b expected %b", bus.err_zero, 1'b0);
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.err_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL err_zero_legal_write: got %b expected %b", bus.err_zero, 1'b0);
        end
        // Set wins over a same-cycle clear.
        set_wr(0, 4'd0, 32'h0000_0005);
        tick();
        idle();
        bus.err_clr = 1'b1;
        set_wr(1, 4'd0, 32'h0000_0007);
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.err_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL err_zero_set_wins: got %b expected %b", bus.err_zero, 1'b1);
        end
        bus.err_clr = 1'b1;
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.err_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL err_zero_clear2: got %b expected %b", bus.err_zero, 1'b0);
        end
    endtask

    task automatic test_scoreboard();
        tick();
        idle();
        set_rd(4'd0, 4'd7);
        bus.iss_en  = 1'b1;
        bus.iss_sel = 4'd7;
        settle();
        n_cmp++;
        if (bus.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_issue_cycle: got %b expected %b", bus.rd_busy[1], 1'b0);
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.rd_busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_issue: got %b expected %b", bus.rd_busy[1], 1'b1);
        end
        tick();
        idle();
        set_wr(1, 4'd7, 32'h0000_0042);
        settle();
        n_cmp++;
        if (bus.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_writeback_bypass: got %b expected %b", bus.rd_busy[1], 1'b0);
        end
        n_cmp++;
        if (rd1 !== 32'h0000_0042) begin
            n_fail++;
            $display("FAIL data_writeback_bypass: got %h expected %h", rd1, 32'h0000_0042);
        end
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_cleared: got %b expected %b", bus.rd_busy[1], 1'b0);
        end
        n_cmp++;
        if (rd1 !== 32'h0000_0042) begin
            n_fail++;
            $display("FAIL data_r7_stored: got %h expected %h", rd1, 32'h0000_0042);
        end
    endtask

    task automatic test_issue_vs_write();
        tick();
        idle();
        set_rd(4'd9, 4'd0);
        bus.iss_en  = 1'b1;
        bus.iss_sel = 4'd9;
        set_wr(0, 4'd9, 32'h0000_0005);
        tick();
        idle();
        settle();
        n_cmp++;
        if (rd0 !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL iss_wr_data: got %h expected %h", rd0, 32'h0000_0005);
        end
        n_cmp++;
        if (bus.rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL iss_wins_busy: got %b expected %b", bus.rd_busy[0], 1'b1);
        end
        // Issue to R0 is ignored.
        set_rd(4'd0, 4'd0);
        bus.iss_en  = 1'b1;
        bus.iss_sel = 4'd0;
        tick();
        idle();
        settle();
        n_cmp++;
        if (bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL iss_r0_ignored: got %b expected %b", bus.rd_busy, 2'b00);
        end
    endtask

    task automatic test_async_reset();
        tick();
        idle();
        set_wr(0, 4'd2, 32'h0000_A5A5);
        set_wr(1, 4'd0, 32'h0000_0003);
        bus.iss_en  = 1'b1;
        bus.iss_sel = 4'd4;
        tick();
        idle();
        set_rd(4'd2, 4'd4);
        settle();
        n_cmp++;
        if (rd0 !== 32'h0000_A5A5 || bus.rd_busy[1] !== 1'b1 || bus.err_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: got %h/%b/%b expected %h/%b/%b",
                     rd0, bus.rd_busy[1], bus.err_zero, 32'h0000_A5A5, 1'b1, 1'b1);
        end
        // Mid-cycle reset with a write and issue pending.
        set_wr(0, 4'd2, 32'h0000_FFFF);
        bus.iss_en  = 1'b1;
        bus.iss_sel = 4'd2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd1, rd0} !== 64'h0 || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_reads: got %h/%b expected %h/%b", {rd1, rd0}, bus.rd_busy, 64'h0, 2'b00);
        end
        n_cmp++;
        if ({bus.err_zero, bus.err_conflict} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_err: got %b expected %b", {bus.err_zero, bus.err_conflict}, 2'b00);
        end
        tick();
        idle();
        rst_n = 1'b1;
        settle();
        n_cmp++;
        if (rd0 !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_r2: got %h expected %h", rd0, 32'h0);
        end
        n_cmp++;
        if (bus.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_r4_busy: got %b expected %b", bus.rd_busy[1], 1'b0);
        end
        tick();
        settle();
        n_cmp++;
        if (rd0 !== 32'h0 || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_hold: got %h/%b expected %h/%b", rd0, bus.rd_busy, 32'h0, 2'b00);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus.rd_sel = '0;
        idle();
        test_reset();
        test_write_bypass();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_issue_vs_write();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_rf_sb.md
# cpu_rf_sb

Parametrised successor to the CPU register file: a multi-ported register file with hardwired-zero R0, same-cycle write-to-read bypass, a per-register busy scoreboard for in-flight producers, and sticky error flags. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which drives one or more write ports. The default parameters give the current 32-bit, 16-entry, 2-read/1-issue configuration with a second write port for the accelerator writeback path.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, register count; power of two, ≥ 2; ADDR_W = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports; higher index has higher priority

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_sel  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  operand not yet valid, combinational
- wr_en  in  NUM_WR  write enables
- wr_sel  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- iss_en  in  1  mark destination busy
- iss_sel  in  ADDR_W  destination being issued
- err_clr  in  1  clear both sticky error flags
- err_zero  out  1  sticky: nonzero write to R0 seen
- err_conflict  out  1  sticky: two enabled write ports hit the same nonzero address in one cycle

## Operation
- Storage: regs[NUM_REGS] of DATA_W bits and busy[NUM_REGS]. R0 storage is never written and always reads 0. busy[0] is always 0.
- Write: for each reg r ≠ 0, if any port w has wr_en[w] and wr_sel[w] == r, then regs[r] takes wr_data of the highest-index such port at the next edge.
- Read, port i: if rd_sel == 0, rd_data = 0. Otherwise, if any enabled write port targets rd_sel this cycle, rd_data is the highest-index such wr_data (bypass). Otherwise rd_data = regs[rd_sel].
- rd_busy[i] = busy[rd_sel] & ~(any enabled write to rd_sel this cycle). It is 0 for rd_sel == 0.
- Scoreboard, per r ≠ 0, next busy[r]:
  - If iss_en and iss_sel == r, next busy[r] = 1. Issue wins over a same-cycle write, because the new producer supersedes the old one.
  - Else, if any enabled write targets r, next busy[r] = 0.
  - Else, hold.
  - iss_en with iss_sel == 0 is ignored.
- Writes are accepted regardless of busy state. The scoreboard is advisory to issue logic.
- err_zero sets when any port has wr_en, wr_sel == 0 and wr_data ≠ 0. A zero write to R0 is legal and silent.
- err_conflict sets when two or more enabled ports share the same wr_sel ≠ 0.
- Each flag holds until err_clr. If err_clr and a new set condition occur in the same cycle, the flag stays set (set wins).

## Timing
- Reset: all regs = 0, all busy = 0, err_zero = err_conflict = 0. rd_data = 0 and rd_busy = 0 for every port while rst_n is low. Reset applies immediately and asynchronously, including mid-write or mid-issue. Writes and issues in progress are discarded.
- Write latency: 1 cycle to storage, 0 cycles to any read port via bypass.
- Issue latency: busy is visible on rd_busy the cycle after iss_en.
- Error flags: registered, asserted the cycle after the offending write, and cleared the cycle after err_clr.
- No combinational path from rd_sel to any registered state. The read path is mux plus bypass compare only.

## Test plan
- Reset, then write R5 = 0xDEADBEEF on port 0. Same cycle: rd_sel0 = 5 reads 0xDEADBEEF (bypass). Next cycle, with no write, it still reads 0xDEADBEEF.
- Port 0 writes R3 = 0x1111 and port 1 writes R3 = 0x2222 in the same cycle. R3 becomes 0x2222. err_conflict rises next cycle and stays high until err_clr; it is then 0 the following cycle.
- Write R0 = 0x1: R0 still reads 0 and err_zero = 1 next cycle. Write R0 = 0x0 after clearing: err_zero stays 0.
- iss_en with iss_sel = 7, then rd_sel1 = 7: rd_busy[1] = 0 in the issue cycle and 1 in the next. Writeback to R7 = 0x42: rd_busy[1] = 0 and rd_data = 0x42 in the same cycle, and busy is clear afterwards.
- In the same cycle, iss_en with iss_sel = 9 and a write to R9 = 0x5: R9 = 0x5 and busy[9] = 1 next cycle. iss_en with iss_sel = 0: no busy is set.
- Load R2 = 0xA5A5 and issue R4, assert rst_n low mid-cycle: all outputs return to 0 immediately. After release, R2 reads 0 and R4 is not busy.
